// File: rtl/nmc_host_if_pkg.sv
// Shared NMC definitions: request/response payloads and host interface FSM states.
package nmc_host_if_pkg;

  // Write request forwarded to the NMC write queue.
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } nmc_wr_req_t;

  // Query request forwarded to the NMC query queue.
  typedef struct packed {
    logic [15:0] key;
  } nmc_qr_req_t;

  // Query response; valid is a one-cycle pulse per completed query.
  typedef struct packed {
    logic        valid;
    logic        found;
    logic [31:0] data;
  } nmc_qr_resp_t;

  // Host interface operating state.
  typedef enum logic [1:0] {
    HI_RUN   = 2'd0,
    HI_DRAIN = 2'd1,
    HI_DONE  = 2'd2
  } hi_state_t;

endpackage

// File: rtl/nmc_host_if_fifo.sv
// Generic synchronous FIFO with simultaneous push/pop support, including when full.
module nmc_host_if_fifo #(
  parameter type fifo_t     = logic [7:0],
  parameter int  FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  fifo_t push_data,
  input  logic  pop,
  output fifo_t pop_data,
  output logic  empty,
  output logic  full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fifo_t            mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == CNT_W'(0));
  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign do_pop_s  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push_s = push & (~full | do_pop_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array write; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/nmc_host_if.sv
// Host command front-end for the NMC: forwards writes/queries, buffers responses,
// tracks query credits and statistics, and sequences a drain/flush handshake.
module nmc_host_if
  import nmc_host_if_pkg::*;
#(
  parameter int RESP_FIFO_DEPTH = 4,
  parameter int CNT_W           = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  nmc_wr_req_t  cmd_wr,
  input  nmc_qr_req_t  cmd_qr,
  output nmc_wr_req_t  nmc_wr_req,
  output logic         nwr_push,
  input  logic         nwr_full,
  output nmc_qr_req_t  nmc_qr_req,
  output logic         nqr_push,
  input  logic         nqr_full,
  input  nmc_qr_resp_t nmc_qr_resp,
  output logic         resp_valid,
  input  logic         resp_ready,
  output nmc_qr_resp_t resp_data,
  input  logic         flush_req,
  output logic         flush_done,
  output logic         idle,
  output logic         ovf_err,
  output logic [CNT_W-1:0] n_query,
  output logic [CNT_W-1:0] n_found
);

  localparam int OUT_W = $clog2(RESP_FIFO_DEPTH + 1);

  hi_state_t        state_r;
  hi_state_t        state_nxt_s;
  logic [OUT_W-1:0] outst_r;
  logic             ovf_r;
  logic [CNT_W-1:0] n_query_r;
  logic [CNT_W-1:0] n_found_r;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             resp_pop_s;
  logic             resp_push_s;
  logic             wr_acc_s;
  logic             qr_acc_s;
  logic             wr_ok_s;
  logic             qr_ok_s;

  // Readiness never looks at resp_ready; it is forced low while in reset.
  assign wr_ok_s    = ~nwr_full;
  assign qr_ok_s    = ~nqr_full & (outst_r < OUT_W'(RESP_FIFO_DEPTH));
  assign cmd_ready  = ~rst & (state_r == HI_RUN) & (cmd_op ? qr_ok_s : wr_ok_s);
  assign wr_acc_s   = cmd_valid & ~cmd_op & cmd_ready;
  assign qr_acc_s   = cmd_valid &  cmd_op & cmd_ready;
  assign nwr_push   = wr_acc_s;
  assign nqr_push   = qr_acc_s;
  assign nmc_wr_req = cmd_wr;
  assign nmc_qr_req = cmd_qr;

  assign resp_valid  = ~fifo_empty_s;
  assign resp_pop_s  = resp_valid & resp_ready;
  assign resp_push_s = nmc_qr_resp.valid & (~fifo_full_s | resp_pop_s);

  assign idle       = (outst_r == OUT_W'(0));
  assign flush_done = (state_r == HI_DONE);
  assign ovf_err    = ovf_r;
  assign n_query    = n_query_r;
  assign n_found    = n_found_r;

  nmc_host_if_fifo #(
    .fifo_t     (nmc_qr_resp_t),
    .FIFO_DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (nmc_qr_resp.valid),
    .push_data (nmc_qr_resp),
    .pop       (resp_pop_s),
    .pop_data  (resp_data),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // State register for the run/drain/done sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HI_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: drain waits for all credits returned and the buffer emptied.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HI_RUN: begin
        if (flush_req) begin
          state_nxt_s = HI_DRAIN;
        end else begin
          state_nxt_s = HI_RUN;
        end
      end
      HI_DRAIN: begin
        if ((outst_r == OUT_W'(0)) && fifo_empty_s) begin
          state_nxt_s = HI_DONE;
        end else begin
          state_nxt_s = HI_DRAIN;
        end
      end
      HI_DONE: state_nxt_s = HI_RUN;
      default: state_nxt_s = HI_RUN;
    endcase
  end

  // Outstanding-query credits; a pop with no credit held (stray response) saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_r <= OUT_W'(0);
    end else if (qr_acc_s && !resp_pop_s) begin
      outst_r <= outst_r + OUT_W'(1);
    end else if (!qr_acc_s && resp_pop_s && (outst_r != OUT_W'(0))) begin
      outst_r <= outst_r - OUT_W'(1);
    end else begin
      outst_r <= outst_r;
    end
  end

  // Sticky overflow flag and wrapping statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r     <= 1'b0;
      n_query_r <= CNT_W'(0);
      n_found_r <= CNT_W'(0);
    end else begin
      if (nmc_qr_resp.valid && fifo_full_s && !resp_pop_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
      if (qr_acc_s) begin
        n_query_r <= n_query_r + CNT_W'(1);
      end else begin
        n_query_r <= n_query_r;
      end
      if (resp_push_s && nmc_qr_resp.found) begin
        n_found_r <= n_found_r + CNT_W'(1);
      end else begin
        n_found_r <= n_found_r;
      end
    end
  end

endmodule

// File: tb/tb_nmc_host_if.sv
// Directed self-checking bench for nmc_host_if (RESP_FIFO_DEPTH=4, CNT_W=32).
module tb_nmc_host_if;
  import nmc_host_if_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, cmd_op;
  nmc_wr_req_t  cmd_wr, nmc_wr_req;
  nmc_qr_req_t  cmd_qr, nmc_qr_req;
  logic         nwr_push, nwr_full, nqr_push, nqr_full;
  nmc_qr_resp_t nmc_qr_resp, resp_data;
  logic         resp_valid, resp_ready;
  logic         flush_req, flush_done, idle, ovf_err;
  logic [31:0]  n_query, n_found;

  int vec_cnt = 0;
  int err_cnt = 0;

  nmc_host_if #(.RESP_FIFO_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wr(cmd_wr), .cmd_qr(cmd_qr),
    .nmc_wr_req(nmc_wr_req), .nwr_push(nwr_push), .nwr_full(nwr_full),
    .nmc_qr_req(nmc_qr_req), .nqr_push(nqr_push), .nqr_full(nqr_full),
    .nmc_qr_resp(nmc_qr_resp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .flush_req(flush_req), .flush_done(flush_done), .idle(idle),
    .ovf_err(ovf_err), .n_query(n_query), .n_found(n_found)
  );

  always #5 clk = ~clk;

  // Issue one query that is expected to be accepted.
  task automatic issue_query(input logic [15:0] key);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_qr.key = key;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // One-cycle response pulse from the NMC.
  task automatic pulse_resp(input logic found, input logic [31:0] data);
    @(negedge clk);
    nmc_qr_resp = '{valid: 1'b1, found: found, data: data};
    @(posedge clk); #1;
    nmc_qr_resp = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; nwr_full = 1'b0; #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || nwr_push !== 1'b0) begin err_cnt++;
      $display("FAIL rst_wr_block: ready=%b push=%b want 0/0", cmd_ready, nwr_push); end
    cmd_op = 1'b1; #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || nqr_push !== 1'b0) begin err_cnt++;
      $display("FAIL rst_qr_block: ready=%b push=%b want 0/0", cmd_ready, nqr_push); end
    vec_cnt++; if (resp_valid !== 1'b0 || idle !== 1'b1 || ovf_err !== 1'b0 || flush_done !== 1'b0) begin err_cnt++;
      $display("FAIL rst_flags: rv=%b idle=%b ovf=%b fd=%b want 0/1/0/0", resp_valid, idle, ovf_err, flush_done); end
    vec_cnt++; if (n_query !== 32'd0 || n_found !== 32'd0) begin err_cnt++;
      $display("FAIL rst_counters: nq=%0d nf=%0d want 0/0", n_query, n_found); end
    cmd_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write;
    nmc_wr_req_t exp_wr;
    exp_wr = '{addr: 16'h1234, data: 32'hdeadbeef};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_wr = exp_wr; nwr_full = 1'b0; #1;
    vec_cnt++; if (cmd_ready !== 1'b1 || nwr_push !== 1'b1 || nqr_push !== 1'b0) begin err_cnt++;
      $display("FAIL wr_accept: ready=%b nwr=%b nqr=%b want 1/1/0", cmd_ready, nwr_push, nqr_push); end
    vec_cnt++; if (nmc_wr_req !== exp_wr) begin err_cnt++;
      $display("FAIL wr_payload: got %h want %h", nmc_wr_req, exp_wr); end
    nwr_full = 1'b1; #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || nwr_push !== 1'b0) begin err_cnt++;
      $display("FAIL wr_full_block: ready=%b push=%b want 0/0", cmd_ready, nwr_push); end
    cmd_valid = 1'b0; nwr_full = 1'b0;
  endtask

  task automatic test_query_limit;
    logic exp_rdy;
    @(negedge clk);
    nqr_full = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b1; cmd_qr.key = 16'h00ff; #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || nqr_push !== 1'b0) begin err_cnt++;
      $display("FAIL qr_full_block: ready=%b push=%b want 0/0", cmd_ready, nqr_push); end
    nqr_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      cmd_qr.key = 16'h0100 + 16'(i); #1;
      exp_rdy = (i < 4);
      vec_cnt++; if (cmd_ready !== exp_rdy || nqr_push !== exp_rdy) begin err_cnt++;
        $display("FAIL qr_credit[%0d]: ready=%b push=%b want %b", i, cmd_ready, nqr_push, exp_rdy); end
      if (exp_rdy) begin
        vec_cnt++; if (nmc_qr_req.key !== 16'h0100 + 16'(i)) begin err_cnt++;
          $display("FAIL qr_payload[%0d]: got %h want %h", i, nmc_qr_req.key, 16'h0100 + 16'(i)); end
      end
      @(posedge clk);
    end
    @(negedge clk); cmd_valid = 1'b0; #1;
    vec_cnt++; if (idle !== 1'b0 || n_query !== 32'd4) begin err_cnt++;
      $display("FAIL qr_limit_stats: idle=%b nq=%0d want 0/4", idle, n_query); end
  endtask

  task automatic test_resp_order;
    logic [3:0] found_tab;
    found_tab = 4'b1101;  // bit i = found flag of response i: 1,0,1,1
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse_resp(found_tab[i], 32'h100 + 32'(i));
    @(negedge clk); #1;
    vec_cnt++; if (resp_valid !== 1'b1 || resp_data.data !== 32'h100 || n_found !== 32'd3 || idle !== 1'b0) begin err_cnt++;
      $display("FAIL resp_buffered: rv=%b data=%h nf=%0d idle=%b want 1/100/3/0", resp_valid, resp_data.data, n_found, idle); end
    @(negedge clk); #1;
    vec_cnt++; if (resp_data.data !== 32'h100) begin err_cnt++;
      $display("FAIL resp_stable: data=%h want 100", resp_data.data); end
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_cnt++; if (resp_valid !== 1'b1 || resp_data.data !== 32'h100 + 32'(i) || resp_data.found !== found_tab[i]) begin err_cnt++;
        $display("FAIL resp_order[%0d]: rv=%b data=%h found=%b want 1/%h/%b", i, resp_valid, resp_data.data, resp_data.found, 32'h100 + 32'(i), found_tab[i]); end
      @(negedge clk);
    end
    resp_ready = 1'b0; #1;
    vec_cnt++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin err_cnt++;
      $display("FAIL resp_drained: rv=%b idle=%b want 0/1", resp_valid, idle); end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_tab [4];
    exp_tab = '{32'h111, 32'h112, 32'h113, 32'h200};
    for (int i = 0; i < 4; i++) issue_query(16'h0200 + 16'(i));
    for (int i = 0; i < 4; i++) pulse_resp(1'b1, 32'h110 + 32'(i));
    @(negedge clk);
    resp_ready = 1'b1; nmc_qr_resp = '{valid: 1'b1, found: 1'b0, data: 32'h200}; #1;
    vec_cnt++; if (ovf_err !== 1'b0) begin err_cnt++;
      $display("FAIL ovf_pre: ovf=%b want 0", ovf_err); end
    @(posedge clk); #1;
    nmc_qr_resp = '0; resp_ready = 1'b0;
    @(negedge clk);
    nmc_qr_resp = '{valid: 1'b1, found: 1'b1, data: 32'h201}; #1;
    vec_cnt++; if (ovf_err !== 1'b0 || resp_data.data !== 32'h111) begin err_cnt++;
      $display("FAIL ovf_push_pop: ovf=%b data=%h want 0/111", ovf_err, resp_data.data); end
    @(posedge clk); #1;
    nmc_qr_resp = '0;
    @(negedge clk); #1;
    vec_cnt++; if (ovf_err !== 1'b1 || n_found !== 32'd7) begin err_cnt++;
      $display("FAIL ovf_set: ovf=%b nf=%0d want 1/7", ovf_err, n_found); end
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (ovf_err !== 1'b1) begin err_cnt++;
      $display("FAIL ovf_sticky: ovf=%b want 1", ovf_err); end
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_cnt++; if (resp_valid !== 1'b1 || resp_data.data !== exp_tab[i]) begin err_cnt++;
        $display("FAIL ovf_drain[%0d]: rv=%b data=%h want 1/%h", i, resp_valid, resp_data.data, exp_tab[i]); end
      @(negedge clk);
    end
    resp_ready = 1'b0; #1;
    vec_cnt++; if (resp_valid !== 1'b0 || idle !== 1'b1 || n_query !== 32'd8 || ovf_err !== 1'b1) begin err_cnt++;
      $display("FAIL ovf_end: rv=%b idle=%b nq=%0d ovf=%b want 0/1/8/1", resp_valid, idle, n_query, ovf_err); end
  endtask

  task automatic test_flush;
    issue_query(16'h0300);
    issue_query(16'h0301);
    @(negedge clk); flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b0; nwr_full = 1'b0; #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || nwr_push !== 1'b0) begin err_cnt++;
      $display("FAIL drain_wr_block: ready=%b push=%b want 0/0", cmd_ready, nwr_push); end
    cmd_op = 1'b1; #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || nqr_push !== 1'b0) begin err_cnt++;
      $display("FAIL drain_qr_block: ready=%b push=%b want 0/0", cmd_ready, nqr_push); end
    cmd_op = 1'b0;
    pulse_resp(1'b0, 32'h300);
    pulse_resp(1'b0, 32'h301);
    @(negedge clk); #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || resp_valid !== 1'b1 || flush_done !== 1'b0) begin err_cnt++;
      $display("FAIL drain_wait: ready=%b rv=%b fd=%b want 0/1/0", cmd_ready, resp_valid, flush_done); end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || flush_done !== 1'b0) begin err_cnt++;
      $display("FAIL drain_one_left: ready=%b fd=%b want 0/0", cmd_ready, flush_done); end
    @(negedge clk); resp_ready = 1'b0; #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || flush_done !== 1'b0 || idle !== 1'b1) begin err_cnt++;
      $display("FAIL drain_empty: ready=%b fd=%b idle=%b want 0/0/1", cmd_ready, flush_done, idle); end
    @(negedge clk); #1;
    vec_cnt++; if (cmd_ready !== 1'b0 || flush_done !== 1'b1) begin err_cnt++;
      $display("FAIL drain_done: ready=%b fd=%b want 0/1", cmd_ready, flush_done); end
    @(negedge clk); #1;
    vec_cnt++; if (cmd_ready !== 1'b1 || nwr_push !== 1'b1 || flush_done !== 1'b0) begin err_cnt++;
      $display("FAIL drain_resume: ready=%b push=%b fd=%b want 1/1/0", cmd_ready, nwr_push, flush_done); end
    cmd_valid = 1'b0;
  endtask

  task automatic test_idle_flush;
    @(negedge clk); flush_req = 1'b1;
    @(posedge clk); #1; flush_req = 1'b0;
    @(negedge clk); #1;
    vec_cnt++; if (flush_done !== 1'b0) begin err_cnt++;
      $display("FAIL idle_flush_c1: fd=%b want 0", flush_done); end
    @(negedge clk); #1;
    vec_cnt++; if (flush_done !== 1'b1) begin err_cnt++;
      $display("FAIL idle_flush_c2: fd=%b want 1", flush_done); end
    @(negedge clk); #1;
    vec_cnt++; if (flush_done !== 1'b0) begin err_cnt++;
      $display("FAIL idle_flush_c3: fd=%b want 0", flush_done); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) issue_query(16'h0400 + 16'(i));
    pulse_resp(1'b1, 32'h400);
    pulse_resp(1'b1, 32'h401);
    @(negedge clk); #1;
    vec_cnt++; if (resp_valid !== 1'b1 || idle !== 1'b0 || n_query !== 32'd13) begin err_cnt++;
      $display("FAIL mid_pre: rv=%b idle=%b nq=%0d want 1/0/13", resp_valid, idle, n_query); end
    rst = 1'b1; #1;
    vec_cnt++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin err_cnt++;
      $display("FAIL mid_rst_flags: rv=%b idle=%b want 0/1", resp_valid, idle); end
    vec_cnt++; if (n_query !== 32'd0 || n_found !== 32'd0 || ovf_err !== 1'b0) begin err_cnt++;
      $display("FAIL mid_rst_counters: nq=%0d nf=%0d ovf=%b want 0/0/0", n_query, n_found, ovf_err); end
    @(negedge clk); rst = 1'b0; #1;
    vec_cnt++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin err_cnt++;
      $display("FAIL mid_post: rv=%b idle=%b want 0/1", resp_valid, idle); end
    issue_query(16'h0500);
    @(negedge clk); #1;
    vec_cnt++; if (n_query !== 32'd1 || idle !== 1'b0) begin err_cnt++;
      $display("FAIL mid_restart: nq=%0d idle=%b want 1/0", n_query, idle); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_wr = '0; cmd_qr = '0;
    nwr_full = 1'b0; nqr_full = 1'b0; nmc_qr_resp = '0; resp_ready = 1'b0; flush_req = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_write;
    test_query_limit;
    test_resp_order;
    test_overflow;
    test_flush;
    test_idle_flush;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/nmc_host_if.md
NMC_HOST_IF -- requirements
Module: nmc_host_if

Interface
REQ-001 SHALL have parameter RESP_FIFO_DEPTH, default 4 (power of two, >=2), giving response buffer entries and maximum outstanding queries.
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the statistics counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-high. Ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-004 SHALL have ports: cmd_valid  in  1  host command valid; cmd_ready  out  1  command accepted this cycle when high with cmd_valid; cmd_op  in  1  0=write, 1=query; cmd_wr  in  nmc_wr_req_t  write payload; cmd_qr  in  nmc_qr_req_t  query payload.
REQ-005 SHALL have ports: nmc_wr_req  out  nmc_wr_req_t; nwr_push  out  1; nwr_full  in  1; nmc_qr_req  out  nmc_qr_req_t; nqr_push  out  1; nqr_full  in  1; nmc_qr_resp  in  nmc_qr_resp_t, a one-cycle valid pulse per completed query.
REQ-006 SHALL have ports: resp_valid  out  1; resp_ready  in  1; resp_data  out  nmc_qr_resp_t  oldest buffered response.
REQ-007 SHALL have ports: flush_req  in  1  drain request; flush_done  out  1  one-cycle drain-complete pulse; idle  out  1  no outstanding queries; ovf_err  out  1  sticky overflow; n_query  out  CNT_W  accepted queries; n_found  out  CNT_W  responses with found=1.

Function
REQ-008 SHALL accept a write (cmd_valid & ~cmd_op) when ~nwr_full and state is HI_RUN; on accept, nwr_push=1 and nmc_wr_req=cmd_wr in the same cycle (combinational pass-through, zero latency).
REQ-009 SHALL accept a query (cmd_valid & cmd_op) when ~nqr_full, outstanding < RESP_FIFO_DEPTH, and state is HI_RUN; on accept, nqr_push=1 and nmc_qr_req=cmd_qr in the same cycle.
REQ-010 SHALL drive cmd_ready from cmd_op and the conditions of REQ-008/009; cmd_ready may depend on cmd_valid/cmd_op but SHALL NOT depend on resp_ready.
REQ-011 SHALL keep an outstanding counter, $clog2(RESP_FIFO_DEPTH+1) bits: +1 on query accept, -1 on response pop (resp_valid & resp_ready), unchanged when both occur in one cycle.
REQ-012 SHALL push nmc_qr_resp into the response FIFO on the cycle nmc_qr_resp.valid=1; entry visible on resp_valid the next cycle.
REQ-013 SHALL hold resp_data stable while resp_valid=1 and resp_ready=0.
REQ-014 SHALL allow simultaneous response push and pop, including when the FIFO is full (pop frees the slot); pointers wrap modulo RESP_FIFO_DEPTH.
REQ-015 SHALL, if a response arrives while the FIFO is full with no pop, drop it and set ovf_err=1 until reset.
REQ-016 SHALL increment n_query on each query accept and n_found on each pushed response with found=1; both wrap at 2^CNT_W.
REQ-017 SHALL drive idle=1 when outstanding==0.
REQ-018 SHALL implement states HI_RUN, HI_DRAIN, HI_DONE: HI_RUN->HI_DRAIN when flush_req=1; HI_DRAIN->HI_DONE when outstanding==0 and response FIFO empty; HI_DONE->HI_RUN unconditionally after one cycle.
REQ-019 SHALL block all command acceptance (cmd_ready=0) in HI_DRAIN and HI_DONE, and pass responses normally.
REQ-020 SHALL assert flush_done=1 only in HI_DONE; flush_req asserted while idle SHALL give flush_done exactly two cycles later.

Reset
REQ-021 SHALL on rst force state HI_RUN, outstanding 0, FIFO pointers/count 0, ovf_err 0, n_query 0, n_found 0, flush_done 0, resp_valid 0; cmd_ready, nwr_push, nqr_push SHALL be 0 while rst=1.
REQ-022 SHALL discard buffered responses and in-flight credits on mid-operation reset; no post-reset response is attributed to pre-reset queries.

Structure
REQ-023 SHALL take nmc_wr_req_t, nmc_qr_req_t, nmc_qr_resp_t from the shared nmc defs package; define hi_state_t there as well.
REQ-024 SHALL instantiate the existing fifo sub-module (fifo_t=nmc_qr_resp_t, FIFO_DEPTH=RESP_FIFO_DEPTH) as the response buffer; all other logic is local.

Verification
REQ-025 Write with nwr_full=0 -> nwr_push=1 same cycle, nmc_wr_req equals cmd_wr; with nwr_full=1 -> cmd_ready=0, nwr_push=0.
REQ-026 Five back-to-back queries, DEPTH=4, no responses -> first four accepted, fifth cmd_ready=0, idle=0, n_query=4.
REQ-027 Four resp pulses (found=1,0,1,1) with resp_ready=0, then resp_ready=1 -> resp_data in arrival order, n_found=3, outstanding returns to 0, idle=1.
REQ-028 FIFO full, resp pulse same cycle as pop -> no drop, ovf_err=0; resp pulse with full FIFO and resp_ready=0 -> ovf_err=1 sticky.
REQ-029 flush_req with 2 outstanding -> cmd_ready=0 until both responses popped, then flush_done one-cycle pulse, then accepts resume.
REQ-030 rst asserted with 3 outstanding and 2 buffered -> resp_valid=0, idle=1, counters 0 immediately, without waiting for a clock edge.
